// File: rtl/c16_pkg.sv
// Shared definitions for the c16 core front end: instruction width, NOP encoding,
// decoder consume-count type and fetch stall margin.
package c16_pkg;

  localparam int unsigned INST_W = 16;

  // Driven on an instruction slot whose valid is low.
  localparam logic [INST_W-1:0] NOP_INST = 16'h0000;

  // Free-entry threshold below which fetch is throttled.
  localparam int unsigned STALL_MARGIN = 4;

  typedef logic [1:0] consume_t;

endpackage

// File: rtl/iq_storage.sv
// Instruction queue storage: DEPTH x INST_W register array with two write ports
// (wptr, wptr+1) and two asynchronous read ports (rptr, rptr+1).
module iq_storage #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INST_W = 16
) (
  input  logic                     clk_i,
  input  logic [$clog2(DEPTH)-1:0] wptr_i,
  input  logic                     we0_i,
  input  logic [INST_W-1:0]        wdata0_i,
  input  logic                     we1_i,
  input  logic [INST_W-1:0]        wdata1_i,
  input  logic [$clog2(DEPTH)-1:0] rptr_i,
  output logic [INST_W-1:0]        rdata0_o,
  output logic [INST_W-1:0]        rdata1_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we0_i) mem_d[wptr_i] = wdata0_i;
    if (we1_i) mem_d[wptr_i + PW'(1)] = wdata1_i;
  end

  // Contents are qualified by the occupancy count, so no reset is needed.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata0_o = mem_q[rptr_i];
  assign rdata1_o = mem_q[rptr_i + PW'(1)];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: 32-bit pushes of two instructions, 0..2 pops per cycle.
// Optional INST_QUEUE_BYPASS_EN forwards incoming halves to empty output slots combinationally.
module inst_queue #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned INST_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*INST_W-1:0]    mem_word,
  input  logic                   mem_valid,
  input  logic                   flush,
  input  logic                   flush_odd,
  input  logic [1:0]             num_consumed,
  output logic [INST_W-1:0]      first_inst,
  output logic                   first_valid,
  output logic [INST_W-1:0]      second_inst,
  output logic                   second_valid,
  output logic                   mem_stall,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  import c16_pkg::*;

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FullCnt  = CW'(DEPTH);
  localparam logic [CW-1:0] StallCnt = CW'(STALL_MARGIN);

  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              skip_q, skip_d;
  logic              overflow_q, overflow_d;

  consume_t          nc;
  logic [CW-1:0]     free, n_need, avail, eff, eff_buf, n_fwd, n_wr;
  logic              push_req, push_ok, byp;
  logic              we0, we1;
  logic [INST_W-1:0] lo, hi, wd0, rd0, rd1, slot0, slot1;

  assign lo = mem_word[INST_W-1:0];
  assign hi = mem_word[2*INST_W-1:INST_W];

  always_comb begin
    nc       = (num_consumed == 2'd3) ? 2'd2 : num_consumed;
    free     = FullCnt - count_q;
    push_req = mem_valid & ~flush;
    n_need   = skip_q ? CW'(1) : CW'(2);
    push_ok  = push_req && (free >= n_need);
`ifdef INST_QUEUE_BYPASS_EN
    byp      = push_ok && (count_q < CW'(2));
`else
    byp      = 1'b0;
`endif
    // Instructions visible to the decoder this cycle, buffered plus forwarded.
    avail    = count_q + (byp ? n_need : '0);
    eff      = (CW'(nc) < avail) ? CW'(nc) : avail;
    eff_buf  = (eff < count_q) ? eff : count_q;
    n_fwd    = eff - eff_buf;
    n_wr     = push_ok ? (n_need - n_fwd) : '0;
    we0      = (n_wr != '0);
    we1      = (n_wr == CW'(2));
    // A single written half is always the high one (skip or low half forwarded).
    wd0      = (n_wr == CW'(1)) ? hi : lo;

    head_d     = head_q + PW'(eff_buf);
    tail_d     = tail_q + PW'(n_wr);
    count_d    = count_q - eff_buf + n_wr;
    skip_d     = push_ok ? 1'b0 : skip_q;
    overflow_d = overflow_q | (push_req & ~push_ok);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      skip_d  = flush_odd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      skip_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      skip_q     <= skip_d;
      overflow_q <= overflow_d;
    end
  end

  iq_storage #(
    .DEPTH  (DEPTH),
    .INST_W (INST_W)
  ) u_storage (
    .clk_i    (clk),
    .wptr_i   (tail_q),
    .we0_i    (we0),
    .wdata0_i (wd0),
    .we1_i    (we1),
    .wdata1_i (hi),
    .rptr_i   (head_q),
    .rdata0_o (rd0),
    .rdata1_o (rd1)
  );

`ifdef INST_QUEUE_BYPASS_EN
  logic [INST_W-1:0] h0;
  assign h0 = skip_q ? hi : lo;

  always_comb begin
    slot0 = (count_q >= CW'(1)) ? rd0 : h0;
    slot1 = (count_q >= CW'(2)) ? rd1 : ((count_q == CW'(1)) ? h0 : hi);
  end
`else
  assign slot0 = rd0;
  assign slot1 = rd1;
`endif

  assign first_valid  = (avail >= CW'(1));
  assign second_valid = (avail >= CW'(2));
  assign first_inst   = first_valid ? slot0 : INST_W'(NOP_INST);
  assign second_inst  = second_valid ? slot1 : INST_W'(NOP_INST);
  assign mem_stall    = ((FullCnt - count_q) < StallCnt);
  assign count        = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue (DEPTH=8): table-driven vectors plus reset and
// same-cycle forwarding sequences; expectations follow INST_QUEUE_BYPASS_EN.
module tb_inst_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] mem_word;
  logic        mem_valid;
  logic        flush;
  logic        flush_odd;
  logic [1:0]  num_consumed;
  logic [15:0] first_inst;
  logic        first_valid;
  logic [15:0] second_inst;
  logic        second_valid;
  logic        mem_stall;
  logic [3:0]  count;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  inst_queue #(
    .DEPTH  (8),
    .INST_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_word     (mem_word),
    .mem_valid    (mem_valid),
    .flush        (flush),
    .flush_odd    (flush_odd),
    .num_consumed (num_consumed),
    .first_inst   (first_inst),
    .first_valid  (first_valid),
    .second_inst  (second_inst),
    .second_valid (second_valid),
    .mem_stall    (mem_stall),
    .count        (count),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mv;
    logic [31:0] word;
    logic        fl;
    logic        fo;
    logic [1:0]  nc;
    logic [15:0] fi;
    logic        fv;
    logic [15:0] si;
    logic        sv;
    logic [3:0]  cnt;
    logic        stall;
    logic        ovf;
  } vec_t;

  localparam int NV = 16;
  vec_t vec [NV];

  function automatic vec_t mk(logic mv, logic [31:0] word, logic fl, logic fo, logic [1:0] nc,
                              logic [15:0] fi, logic fv, logic [15:0] si, logic sv,
                              logic [3:0] cnt, logic stall, logic ovf);
    vec_t v;
    v.mv = mv; v.word = word; v.fl = fl; v.fo = fo; v.nc = nc;
    v.fi = fi; v.fv = fv; v.si = si; v.sv = sv;
    v.cnt = cnt; v.stall = stall; v.ovf = ovf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_valid    = 1'b0;
    mem_word     = 32'h0;
    flush        = 1'b0;
    flush_odd    = 1'b0;
    num_consumed = 2'd0;
  endtask

  task automatic chk_outputs(input int idx, input logic [15:0] fi, input logic fv,
                             input logic [15:0] si, input logic sv, input logic [3:0] cnt,
                             input logic stall, input logic ovf);
    chk("first_inst", idx, 32'(first_inst), 32'(fi));
    chk("first_valid", idx, 32'(first_valid), 32'(fv));
    chk("second_inst", idx, 32'(second_inst), 32'(si));
    chk("second_valid", idx, 32'(second_valid), 32'(sv));
    chk("count", idx, 32'(count), 32'(cnt));
    chk("mem_stall", idx, 32'(mem_stall), 32'(stall));
    chk("overflow", idx, 32'(overflow), 32'(ovf));
  endtask

  initial begin
    //              mv  word          fl fo nc  fi     fv si     sv cnt st ovf
    vec[0]  = mk(1, 32'hBBBB_AAAA, 0, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, 2, 0, 0);
    vec[1]  = mk(1, 32'h4444_3333, 0, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, 4, 0, 0);
    vec[2]  = mk(1, 32'h6666_5555, 0, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, 6, 1, 0);
    vec[3]  = mk(1, 32'h8888_7777, 0, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, 8, 1, 0);
    vec[4]  = mk(1, 32'h9999_9999, 0, 0, 0, 16'hAAAA, 1, 16'hBBBB, 1, 8, 1, 1);
    vec[5]  = mk(0, 32'h0,         0, 0, 2, 16'h3333, 1, 16'h4444, 1, 6, 1, 1);
    vec[6]  = mk(0, 32'h0,         0, 0, 3, 16'h5555, 1, 16'h6666, 1, 4, 0, 1);
    vec[7]  = mk(0, 32'h0,         0, 0, 1, 16'h6666, 1, 16'h7777, 1, 3, 0, 1);
    vec[8]  = mk(1, 32'h0B0B_0A0A, 0, 0, 2, 16'h8888, 1, 16'h0A0A, 1, 3, 0, 1);
    vec[9]  = mk(0, 32'h0,         0, 0, 2, 16'h0B0B, 1, 16'h0000, 0, 1, 0, 1);
    vec[10] = mk(0, 32'h0,         0, 0, 2, 16'h0000, 0, 16'h0000, 0, 0, 0, 1);
    vec[11] = mk(1, 32'hFFFF_EEEE, 1, 1, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 1);
    vec[12] = mk(1, 32'h2222_1111, 0, 0, 0, 16'h2222, 1, 16'h0000, 0, 1, 0, 1);
    vec[13] = mk(1, 32'h4444_3333, 0, 0, 0, 16'h2222, 1, 16'h3333, 1, 3, 0, 1);
    vec[14] = mk(1, 32'h7777_7777, 1, 0, 2, 16'h0000, 0, 16'h0000, 0, 0, 0, 1);
    vec[15] = mk(1, 32'h6666_5555, 0, 0, 0, 16'h5555, 1, 16'h6666, 1, 2, 0, 1);

    idle_inputs();
    rst = 1'b1;
    #1;
    chk_outputs(-1, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Each step: drive at negedge, take the edge, go idle and check registered state.
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      mem_valid    = vec[i].mv;
      mem_word     = vec[i].word;
      flush        = vec[i].fl;
      flush_odd    = vec[i].fo;
      num_consumed = vec[i].nc;
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      chk_outputs(i, vec[i].fi, vec[i].fv, vec[i].si, vec[i].sv, vec[i].cnt, vec[i].stall,
                  vec[i].ovf);
    end

    // Asynchronous reset mid-operation clears everything, including sticky overflow.
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_outputs(100, 16'h0, 1'b0, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Empty queue, push and consume two in the same cycle.
    @(negedge clk);
    mem_valid    = 1'b1;
    mem_word     = 32'hDDDD_CCCC;
    num_consumed = 2'd2;
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_first_valid", 200, 32'(first_valid), 32'd1);
    chk("byp_first_inst", 200, 32'(first_inst), 32'hCCCC);
    chk("byp_second_valid", 200, 32'(second_valid), 32'd1);
    chk("byp_second_inst", 200, 32'(second_inst), 32'hDDDD);
`else
    chk("byp_first_valid", 200, 32'(first_valid), 32'd0);
    chk("byp_first_inst", 200, 32'(first_inst), 32'h0);
    chk("byp_second_valid", 200, 32'(second_valid), 32'd0);
    chk("byp_second_inst", 200, 32'(second_inst), 32'h0);
`endif
    @(posedge clk);
    #1;
    idle_inputs();
    #1;
`ifdef INST_QUEUE_BYPASS_EN
    chk("byp_count", 201, 32'(count), 32'd0);
    chk("byp_first_valid_after", 201, 32'(first_valid), 32'd0);
`else
    chk("byp_count", 201, 32'(count), 32'd2);
    chk("byp_first_inst_after", 201, 32'(first_inst), 32'hCCCC);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
